// File: rtl/instruction_status_latch_if.sv
// Fetch/flag bundle between control unit, instruction memory and the status latch.
// The slave modport is the latch; the master side drives strobes, memory data and ALU results.
interface instruction_status_latch_if #(
    parameter int unsigned IW = 32
);
    logic          fetch_req;
    logic [IW-1:0] mem_data;
    logic          mem_ready;
    logic          set_flags;
    logic [3:0]    alu_flags;
    logic          alu_zero;
    logic [IW-1:0] instruction;
    logic          ir_valid;
    logic          fetch_busy;
    logic          fetch_error;
    logic [4:0]    status;

    modport master (
        output fetch_req, mem_data, mem_ready, set_flags, alu_flags, alu_zero,
        input  instruction, ir_valid, fetch_busy, fetch_error, status
    );

    modport slave (
        input  fetch_req, mem_data, mem_ready, set_flags, alu_flags, alu_zero,
        output instruction, ir_valid, fetch_busy, fetch_error, status
    );
endinterface

// File: rtl/instruction_status_latch.sv
// Instruction register with bounded-wait fetch handshake, plus the NZCV flag register
// and the 5-bit status bus consumed by the LEGv8 control unit.
module instruction_status_latch #(
    parameter int unsigned IW      = 32,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic                          clock,
    input  logic                          reset,
    instruction_status_latch_if.slave     bus
);
    localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StWait, StHold} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [IW-1:0]   instr_q, instr_d;
    logic            valid_q, valid_d;
    logic            error_q, error_d;
    logic [3:0]      flags_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            instr_q <= '0;
            valid_q <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
            error_q <= error_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        instr_d = instr_q;
        valid_d = valid_q;
        error_d = error_q;
        unique case (state_q)
            StIdle, StHold: begin
                if (bus.fetch_req) begin
                    state_d = StWait;
                    cnt_d   = '0;
                    valid_d = 1'b0;
                    error_d = 1'b0;
                end
            end
            StWait: begin
                // Ready wins over timeout in the same cycle; fetch_req cannot restart.
                if (bus.mem_ready) begin
                    instr_d = bus.mem_data;
                    valid_d = 1'b1;
                    state_d = StHold;
                end else if (cnt_q == CntLast) begin
                    error_d = 1'b1;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Flag register is independent of the fetch FSM.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            flags_q <= '0;
        end else if (bus.set_flags) begin
            flags_q <= bus.alu_flags;
        end
    end

    assign bus.instruction = instr_q;
    assign bus.ir_valid    = valid_q;
    assign bus.fetch_busy  = (state_q == StWait);
    assign bus.fetch_error = error_q;
    assign bus.status      = {flags_q, bus.alu_zero};
endmodule

// File: tb/tb_instruction_status_latch.sv
// Randomized self-checking bench for instruction_status_latch against a transaction-level model.
module tb_instruction_status_latch;
    localparam int unsigned IW      = 32;
    localparam int unsigned TIMEOUT = 15;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    // Transaction-level model of observable state.
    logic [IW-1:0] exp_instr = '0;
    logic          exp_valid = 1'b0;
    logic          exp_error = 1'b0;
    logic [3:0]    exp_flags = '0;

    instruction_status_latch_if #(.IW(IW)) bus ();

    instruction_status_latch #(.IW(IW), .TIMEOUT(TIMEOUT)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // A fetch whose ready arrives in WAIT cycle 'delay' succeeds if delay <= TIMEOUT.
    task automatic model_fetch(input logic [IW-1:0] data, input int delay, output int exp_busy);
        if (delay <= int'(TIMEOUT)) begin
            exp_instr = data;
            exp_valid = 1'b1;
            exp_error = 1'b0;
            exp_busy  = delay;
        end else begin
            exp_valid = 1'b0;
            exp_error = 1'b1;
            exp_busy  = TIMEOUT;
        end
    endtask

    // Issues one fetch; ready is driven in the delay-th busy cycle, junk data otherwise.
    task automatic run_fetch(input logic [IW-1:0] data, input int delay, output int busy_cycles);
        bus.fetch_req = 1'b1;
        tick();
        bus.fetch_req = 1'b0;
        busy_cycles = 0;
        for (int c = 1; c <= int'(TIMEOUT) + 2; c++) begin
            if (!bus.fetch_busy) break;
            busy_cycles++;
            bus.mem_ready = (c == delay);
            bus.mem_data  = (c == delay) ? data : $urandom;
            tick();
        end
        bus.mem_ready = 1'b0;
    endtask

    task automatic test_reset();
        bus.fetch_req = 0; bus.mem_data = '0; bus.mem_ready = 0;
        bus.set_flags = 0; bus.alu_flags = '0; bus.alu_zero = 0;
        reset = 1'b0;
        #1;
        checks++;
        if (bus.instruction !== '0 || bus.ir_valid !== 1'b0 || bus.fetch_busy !== 1'b0 ||
            bus.fetch_error !== 1'b0 || bus.status !== 5'b00000) begin
            failures++;
            $display("FAIL reset_state: instr=%h valid=%b busy=%b err=%b status=%b, want 0/0/0/0/00000",
                     bus.instruction, bus.ir_valid, bus.fetch_busy, bus.fetch_error, bus.status);
        end
        bus.alu_zero = 1'b1;
        #1;
        checks++;
        if (bus.status !== 5'b00001) begin
            failures++;
            $display("FAIL reset_status_zero: status=%b want 00001", bus.status);
        end
        bus.alu_zero = 1'b0;
        tick();
        #3 reset = 1'b1;
        tick();
    endtask

    task automatic test_fetch_basic();
        int busy, eb;
        model_fetch(32'h8B02_0020, 2, eb);
        run_fetch(32'h8B02_0020, 2, busy);
        checks++;
        if (busy != eb || bus.instruction !== exp_instr || bus.ir_valid !== exp_valid ||
            bus.fetch_error !== exp_error) begin
            failures++;
            $display("FAIL basic_fetch: busy=%0d instr=%h valid=%b err=%b, want %0d %h %b %b",
                     busy, bus.instruction, bus.ir_valid, bus.fetch_error,
                     eb, exp_instr, exp_valid, exp_error);
        end
        // HOLD ignores mem_ready and data changes.
        for (int i = 0; i < 4; i++) begin
            bus.mem_ready = 1'b1;
            bus.mem_data  = $urandom;
            tick();
        end
        bus.mem_ready = 1'b0;
        checks++;
        if (bus.instruction !== exp_instr || bus.ir_valid !== 1'b1 || bus.fetch_busy !== 1'b0) begin
            failures++;
            $display("FAIL hold_stable: instr=%h valid=%b busy=%b, want %h 1 0",
                     bus.instruction, bus.ir_valid, bus.fetch_busy, exp_instr);
        end
    endtask

    task automatic test_timeout();
        int busy, eb;
        model_fetch(32'hDEAD_BEEF, 20, eb);
        run_fetch(32'hDEAD_BEEF, 20, busy);
        checks++;
        if (busy != eb || bus.fetch_error !== 1'b1 || bus.ir_valid !== 1'b0 ||
            bus.instruction !== exp_instr || bus.fetch_busy !== 1'b0) begin
            failures++;
            $display("FAIL timeout: busy=%0d err=%b valid=%b instr=%h, want %0d 1 0 %h",
                     busy, bus.fetch_error, bus.ir_valid, bus.instruction, eb, exp_instr);
        end
        bus.fetch_req = 1'b1;
        tick();
        bus.fetch_req = 1'b0;
        checks++;
        if (bus.fetch_error !== 1'b0 || bus.fetch_busy !== 1'b1) begin
            failures++;
            $display("FAIL error_clear: err=%b busy=%b want 0 1", bus.fetch_error, bus.fetch_busy);
        end
        bus.mem_ready = 1'b1;
        bus.mem_data  = 32'h1234_5678;
        tick();
        bus.mem_ready = 1'b0;
        exp_instr = 32'h1234_5678; exp_valid = 1'b1; exp_error = 1'b0;
        checks++;
        if (bus.instruction !== exp_instr || bus.ir_valid !== 1'b1) begin
            failures++;
            $display("FAIL fetch_after_error: instr=%h valid=%b want %h 1",
                     bus.instruction, bus.ir_valid, exp_instr);
        end
    endtask

    task automatic test_ready_last();
        int busy, eb;
        model_fetch(32'hCAFE_F00D, TIMEOUT, eb);
        run_fetch(32'hCAFE_F00D, TIMEOUT, busy);
        checks++;
        if (busy != eb || bus.instruction !== exp_instr || bus.ir_valid !== 1'b1 ||
            bus.fetch_error !== 1'b0) begin
            failures++;
            $display("FAIL ready_last_cycle: busy=%0d instr=%h valid=%b err=%b, want %0d %h 1 0",
                     busy, bus.instruction, bus.ir_valid, bus.fetch_error, eb, exp_instr);
        end
    endtask

    task automatic test_flags();
        bus.fetch_req = 1'b1;
        tick();
        bus.fetch_req = 1'b0;
        bus.set_flags = 1'b1;
        bus.alu_flags = 4'b0101;
        tick();
        bus.set_flags = 1'b0;
        exp_flags = 4'b0101;
        checks++;
        if (bus.status[4:1] !== exp_flags || bus.fetch_busy !== 1'b1 || bus.ir_valid !== 1'b0) begin
            failures++;
            $display("FAIL flags_in_wait: status=%b busy=%b valid=%b want %b 1 0",
                     bus.status[4:1], bus.fetch_busy, bus.ir_valid, exp_flags);
        end
        bus.alu_flags = 4'b1010;
        tick();
        checks++;
        if (bus.status[4:1] !== exp_flags) begin
            failures++;
            $display("FAIL flags_hold: status=%b want %b", bus.status[4:1], exp_flags);
        end
        bus.alu_zero = 1'b1;
        #1;
        checks++;
        if (bus.status[0] !== 1'b1) begin
            failures++;
            $display("FAIL zero_passthru_hi: status0=%b want 1", bus.status[0]);
        end
        bus.alu_zero = 1'b0;
        #1;
        checks++;
        if (bus.status[0] !== 1'b0) begin
            failures++;
            $display("FAIL zero_passthru_lo: status0=%b want 0", bus.status[0]);
        end
        bus.mem_ready = 1'b1;
        bus.mem_data  = 32'h0F0F_A5A5;
        @(posedge clock);
        #1;
        bus.mem_ready = 1'b0;
        exp_instr = 32'h0F0F_A5A5; exp_valid = 1'b1; exp_error = 1'b0;
        checks++;
        if (bus.instruction !== exp_instr || bus.ir_valid !== 1'b1) begin
            failures++;
            $display("FAIL fetch_with_flags: instr=%h valid=%b want %h 1",
                     bus.instruction, bus.ir_valid, exp_instr);
        end
        // Random flag traffic.
        for (int i = 0; i < 20; i++) begin
            logic [3:0] f;
            logic       s;
            f = 4'($urandom);
            s = 1'($urandom);
            bus.set_flags = s;
            bus.alu_flags = f;
            bus.alu_zero  = 1'($urandom);
            if (s) exp_flags = f;
            tick();
            checks++;
            if (bus.status !== {exp_flags, bus.alu_zero}) begin
                failures++;
                $display("FAIL flags_random[%0d]: status=%b want %b", i, bus.status,
                         {exp_flags, bus.alu_zero});
            end
        end
        bus.set_flags = 1'b0;
        bus.alu_zero  = 1'b0;
    endtask

    task automatic test_async_reset();
        bus.set_flags = 1'b1;
        bus.alu_flags = 4'b1111;
        bus.fetch_req = 1'b1;
        tick();
        bus.set_flags = 1'b0;
        bus.fetch_req = 1'b0;
        exp_flags = 4'b1111;
        checks++;
        if (bus.fetch_busy !== 1'b1 || bus.status[4:1] !== 4'b1111) begin
            failures++;
            $display("FAIL pre_reset: busy=%b flags=%b want 1 1111", bus.fetch_busy, bus.status[4:1]);
        end
        #2 reset = 1'b0;
        #1;
        exp_instr = '0; exp_valid = 1'b0; exp_error = 1'b0; exp_flags = '0;
        checks++;
        if (bus.instruction !== '0 || bus.ir_valid !== 1'b0 || bus.fetch_busy !== 1'b0 ||
            bus.fetch_error !== 1'b0 || bus.status !== 5'b00000) begin
            failures++;
            $display("FAIL async_reset: instr=%h valid=%b busy=%b err=%b status=%b, want all 0",
                     bus.instruction, bus.ir_valid, bus.fetch_busy, bus.fetch_error, bus.status);
        end
        #1 reset = 1'b1;
        bus.mem_ready = 1'b1;
        bus.mem_data  = 32'hFFFF_FFFF;
        tick();
        bus.mem_ready = 1'b0;
        checks++;
        if (bus.ir_valid !== 1'b0 || bus.instruction !== '0 || bus.fetch_busy !== 1'b0) begin
            failures++;
            $display("FAIL ready_after_reset: valid=%b instr=%h busy=%b want 0 0 0",
                     bus.ir_valid, bus.instruction, bus.fetch_busy);
        end
    endtask

    task automatic test_back_to_back();
        int busy, eb;
        logic [IW-1:0] old_word;
        model_fetch(32'hAAAA_5555, 1, eb);
        run_fetch(32'hAAAA_5555, 1, busy);
        old_word = exp_instr;
        bus.fetch_req = 1'b1;
        bus.mem_ready = 1'b1;
        bus.mem_data  = 32'h1111_2222;
        tick();
        bus.fetch_req = 1'b0;
        bus.mem_ready = 1'b0;
        exp_valid = 1'b0;
        checks++;
        if (bus.fetch_busy !== 1'b1 || bus.ir_valid !== 1'b0 || bus.instruction !== old_word) begin
            failures++;
            $display("FAIL b2b_accept: busy=%b valid=%b instr=%h want 1 0 %h",
                     bus.fetch_busy, bus.ir_valid, bus.instruction, old_word);
        end
        tick();
        bus.mem_ready = 1'b1;
        bus.mem_data  = 32'h3333_4444;
        tick();
        bus.mem_ready = 1'b0;
        exp_instr = 32'h3333_4444; exp_valid = 1'b1;
        checks++;
        if (bus.instruction !== exp_instr || bus.ir_valid !== 1'b1 || bus.fetch_busy !== 1'b0) begin
            failures++;
            $display("FAIL b2b_latch: instr=%h valid=%b busy=%b want %h 1 0",
                     bus.instruction, bus.ir_valid, bus.fetch_busy, exp_instr);
        end
    endtask

    task automatic test_random_fetches();
        int busy, eb, delay;
        logic [IW-1:0] data;
        for (int i = 0; i < 30; i++) begin
            delay = $urandom_range(TIMEOUT + 3, 1);
            data  = $urandom;
            model_fetch(data, delay, eb);
            run_fetch(data, delay, busy);
            checks++;
            if (busy != eb || bus.instruction !== exp_instr || bus.ir_valid !== exp_valid ||
                bus.fetch_error !== exp_error || bus.fetch_busy !== 1'b0) begin
                failures++;
                $display("FAIL random_fetch[%0d] d=%0d: busy=%0d instr=%h valid=%b err=%b, want %0d %h %b %b",
                         i, delay, busy, bus.instruction, bus.ir_valid, bus.fetch_error,
                         eb, exp_instr, exp_valid, exp_error);
            end
            for (int j = $urandom_range(2, 0); j > 0; j--) tick();
        end
    endtask

    initial begin
        test_reset();
        test_fetch_basic();
        test_timeout();
        test_ready_last();
        test_flags();
        test_async_reset();
        test_back_to_back();
        test_random_fetches();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/instruction_status_latch.md
# instruction_status_latch

Fetch-side companion stage that sits directly upstream of the LEGv8 control unit. It captures the instruction word from memory during the instruction-fetch state, using a ready handshake with a bounded wait, and holds it stable for the decode/execute control words. It also owns the architectural NZCV flag register and assembles the 5-bit `status` bus that the control unit's state sequencing consumes.

## Interface
Parameters:
- `IW`, 32, instruction word width
- `TIMEOUT`, 15, maximum WAIT cycles before a fetch is abandoned (≥2)

Ports:
- `clock`  in  1  single system clock, rising edge
- `reset`  in  1  asynchronous, active-low reset; clears all state
- `fetch_req`  in  1  IR-load strobe from the current control word (asserted in IF state)
- `mem_data`  in  IW  instruction word from instruction memory
- `mem_ready`  in  1  memory indicates `mem_data` valid this cycle
- `set_flags`  in  1  flag-load strobe from control word (ADDS/SUBS/ANDS…)
- `alu_flags`  in  4  ALU {V,C,N,Z} of current operation
- `alu_zero`  in  1  live ALU zero, for CBZ/CBNZ
- `instruction`  out  IW  latched instruction register
- `ir_valid`  out  1  `instruction` holds a completed fetch
- `fetch_busy`  out  1  fetch outstanding (state WAIT)
- `fetch_error`  out  1  sticky: last fetch timed out
- `status`  out  5  {V,C,N,Z (registered), alu_zero (live)} to control unit

## Operation
- FSM states: IDLE, WAIT, HOLD (2-bit encoding, free).
- IDLE: `fetch_req`=1 → WAIT; clear wait counter, clear `ir_valid`, clear `fetch_error`.
- WAIT: `mem_ready`=1 → latch `mem_data` into `instruction`, set `ir_valid`, → HOLD. Otherwise increment counter; if counter = TIMEOUT-1 and no ready → set `fetch_error`, leave `ir_valid`=0, keep `instruction` unchanged, → IDLE.
- WAIT: `fetch_req` ignored (no restart); `mem_ready` wins over timeout in the same cycle.
- HOLD: `instruction` and `ir_valid` stable; `fetch_req`=1 → WAIT with same actions as from IDLE.
- `mem_ready` in IDLE/HOLD ignored.
- Counter width ceil(log2(TIMEOUT)); never wraps (leaves WAIT first).
- Flags: `set_flags`=1 → flag reg ← `alu_flags` at the edge; else hold. Independent of FSM state (allowed during WAIT).
- `status[4:1]` = flag reg {V,C,N,Z}; `status[0]` = `alu_zero` combinational pass-through.
- `fetch_busy` = (state == WAIT), decoded from registered state only.

## Timing
- Reset (async assert, `reset`=0): state IDLE, `instruction`=0, `ir_valid`=0, `fetch_busy`=0, `fetch_error`=0, flag reg=0, counter=0. `status`=`{4'b0, alu_zero}`.
- Reset assertion mid-WAIT abandons the fetch immediately; no partial latch.
- Reset release takes effect on the first rising edge with `reset`=1.
- Latency: `fetch_req` sampled at edge N → WAIT after N; `mem_ready` sampled at edge N+k (k≥1) → `instruction`/`ir_valid` valid after N+k. Minimum 2 edges req→valid.
- `ir_valid` drops the cycle after a new `fetch_req` is accepted.
- Timeout: with no ready, `fetch_error` rises after edge N+TIMEOUT, same edge that returns to IDLE; `fetch_busy` high for exactly TIMEOUT cycles.
- Flag update visible on `status` the cycle after the `set_flags` edge; `alu_zero` zero-latency.

## Test plan
- Reset then `fetch_req` 1 cycle, `mem_ready` 2 cycles later with `mem_data`=0x8B020020 → `fetch_busy` high 2 cycles, `instruction`=0x8B020020, `ir_valid`=1, then stable in HOLD.
- `fetch_req` and no `mem_ready` for 20 cycles (TIMEOUT=15) → `fetch_busy` high exactly 15 cycles, `fetch_error`=1, `ir_valid`=0, `instruction` keeps previous value; next `fetch_req` clears `fetch_error`.
- `mem_ready` on the 15th WAIT cycle → fetch succeeds, `fetch_error` stays 0.
- `set_flags`=1 with `alu_flags`=4'b0101 during WAIT → `status[4:1]`=0101 next cycle, fetch unaffected; `set_flags`=0 with changed `alu_flags` → `status[4:1]` holds; toggle `alu_zero` → `status[0]` follows same cycle.
- `reset` pulsed low asynchronously (between edges) in WAIT with flags=1111 → all outputs to reset values immediately, `mem_ready` next edge ignored (IDLE).
- Back-to-back: `fetch_req` in HOLD on same cycle `mem_ready` high → re-enters WAIT, `ir_valid`=0, new word latched only on a later `mem_ready`.
